// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: two-master round-robin arbiter (CPU = M0, DMA/loader = M1) in front of the system bridge.
// Optional macro PR_ARB_TIMEOUT_EN adds a wait-cycle timeout that force-completes a stalled transfer and sets Bus_Err.
module pr_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned RR_INIT        = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [29:0] M0_A,
    input  logic [3:0]  M0_BE,
    input  logic [31:0] M0_WData,
    input  logic        M0_Req,
    input  logic        M0_RW,
    output logic [31:0] M0_RData,
    output logic        M0_Ready,
    input  logic [29:0] M1_A,
    input  logic [3:0]  M1_BE,
    input  logic [31:0] M1_WData,
    input  logic        M1_Req,
    input  logic        M1_RW,
    output logic [31:0] M1_RData,
    output logic        M1_Ready,
    output logic [29:0] PrA,
    output logic [3:0]  PrBE,
    output logic [31:0] PrWData,
    output logic        PrReq,
    output logic        PrRW,
    input  logic [31:0] PrRData,
    input  logic        PrReady,
    output logic [1:0]  Grant,
    output logic        Bus_Err
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   own_req, timeout, done;
    logic [31:0] rdata;

    assign own_req = (state_q == OWN0) ? M0_Req : (state_q == OWN1) ? M1_Req : 1'b0;
`ifdef PR_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q;
    assign timeout = own_req && !PrReady && (cnt_q == 8'(TIMEOUT_CYCLES));
    assign cnt_d   = (state_q == IDLE || done) ? 8'd0 : (PrReq && !PrReady) ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout;
        end
    end
    assign Bus_Err = err_q;
`else
    assign timeout = 1'b0;
    assign Bus_Err = 1'b0;
`endif
    assign PrReq    = own_req && !timeout;
    assign done     = (PrReq && PrReady) || timeout;
    assign Grant    = {state_q == OWN1, state_q == OWN0};
    assign PrA      = Grant[0] ? M0_A     : Grant[1] ? M1_A     : 30'h0;
    assign PrBE     = Grant[0] ? M0_BE    : Grant[1] ? M1_BE    : 4'h0;
    assign PrWData  = Grant[0] ? M0_WData : Grant[1] ? M1_WData : 32'h0;
    assign PrRW     = Grant[0] ? M0_RW    : Grant[1] ? M1_RW    : 1'b0;
    assign rdata    = timeout ? 32'hFFFF_FFFF : PrRData;
    assign M0_Ready = Grant[0] && done;
    assign M1_Ready = Grant[1] && done;
    assign M0_RData = M0_Ready ? rdata : 32'h0;
    assign M1_RData = M1_Ready ? rdata : 32'h0;

    // ptr_q names the master favoured on a tie; it always points away from the last winner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (M0_Req && (!M1_Req || !ptr_q)) begin
                state_d = OWN0;
                ptr_d   = 1'b1;
            end else if (M1_Req) begin
                state_d = OWN1;
                ptr_d   = 1'b0;
            end
        end else if (done) begin
            if (state_q == OWN0 && M1_Req && ptr_q) begin
                state_d = OWN1;
                ptr_d   = 1'b0;
            end else if (state_q == OWN1 && M0_Req && !ptr_q) begin
                state_d = OWN0;
                ptr_d   = 1'b1;
            end else if (!own_req) begin
                state_d = IDLE;
            end
        end else if (!own_req) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'(RR_INIT);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb_pr_bus_arbiter: directed and randomized checks of pr_bus_arbiter against a transaction-level model.
// Build with PR_ARB_TIMEOUT_EN defined to exercise the timeout path.
module tb_pr_bus_arbiter;
`ifdef PR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [29:0] m0_a, m1_a, pr_a;
    logic [3:0]  m0_be, m1_be, pr_be;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, pr_wdata, pr_rdata;
    logic        m0_req, m1_req, m0_rw, m1_rw, m0_ready, m1_ready;
    logic        pr_req, pr_rw, pr_ready, bus_err;
    logic [1:0]  grant;

    int n_chk = 0, n_pass = 0;
    int own = -1, fav = 0, cnt = 0;
    bit err = 1'b0;
    logic        e_prreq, e_done, e_r0, e_r1, e_to, e_prrw;
    logic [1:0]  e_grant;
    logic [29:0] e_pra;
    logic [3:0]  e_prbe;
    logic [31:0] e_prwd, e_rd;
    logic [136:0] exp_v, act_v;

    always #5 clk = ~clk;
    assign act_v = {grant, pr_req, pr_a, pr_be, pr_wdata, pr_rw, m0_ready, m1_ready, bus_err, m0_rdata, m1_rdata};

    pr_bus_arbiter #(.TIMEOUT_CYCLES(TO), .RR_INIT(0)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .M0_A(m0_a), .M0_BE(m0_be), .M0_WData(m0_wdata), .M0_Req(m0_req), .M0_RW(m0_rw),
        .M0_RData(m0_rdata), .M0_Ready(m0_ready),
        .M1_A(m1_a), .M1_BE(m1_be), .M1_WData(m1_wdata), .M1_Req(m1_req), .M1_RW(m1_rw),
        .M1_RData(m1_rdata), .M1_Ready(m1_ready),
        .PrA(pr_a), .PrBE(pr_be), .PrWData(pr_wdata), .PrReq(pr_req), .PrRW(pr_rw),
        .PrRData(pr_rdata), .PrReady(pr_ready), .Grant(grant), .Bus_Err(bus_err)
    );

    function automatic logic req_of(int m);
        return (m == 0) ? m0_req : m1_req;
    endfunction

    task automatic model_reset();
        own = -1;
        fav = 0;
        cnt = 0;
        err = 1'b0;
    endtask

    // Expected bus view for the current cycle, from the owner, its request and the slave handshake.
    task automatic model_eval();
        logic ro;
        ro      = (own >= 0) ? req_of(own) : 1'b0;
        e_to    = TO_EN && ro && !pr_ready && cnt == TO;
        e_prreq = ro && !e_to;
        e_done  = (e_prreq && pr_ready) || e_to;
        e_grant = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        e_pra   = (own == 0) ? m0_a : (own == 1) ? m1_a : 30'h0;
        e_prbe  = (own == 0) ? m0_be : (own == 1) ? m1_be : 4'h0;
        e_prwd  = (own == 0) ? m0_wdata : (own == 1) ? m1_wdata : 32'h0;
        e_prrw  = (own == 0) ? m0_rw : (own == 1) ? m1_rw : 1'b0;
        e_r0    = (own == 0) && e_done;
        e_r1    = (own == 1) && e_done;
        e_rd    = e_to ? 32'hFFFF_FFFF : pr_rdata;
        exp_v   = {e_grant, e_prreq, e_pra, e_prbe, e_prwd, e_prrw, e_r0, e_r1, err,
                   e_r0 ? e_rd : 32'h0, e_r1 ? e_rd : 32'h0};
    endtask

    task automatic model_advance();
        int oth;
        if (e_to) err = 1'b1;
        if (own < 0) begin
            if (m0_req && m1_req) own = fav;
            else if (m0_req) own = 0;
            else if (m1_req) own = 1;
            if (own >= 0) fav = 1 - own;
            cnt = 0;
        end else if (e_done) begin
            oth = 1 - own;
            if (req_of(oth) && fav == oth) begin
                own = oth;
                fav = 1 - oth;
            end else if (!req_of(own)) begin
                own = -1;
            end
            cnt = 0;
        end else if (!req_of(own)) begin
            own = -1;
            cnt = 0;
        end else if (!pr_ready) begin
            cnt++;
        end
    endtask

    task automatic idle_inputs();
        {m0_a, m0_be, m0_wdata, m0_req, m0_rw} = '0;
        {m1_a, m1_be, m1_wdata, m1_req, m1_rw} = '0;
        pr_ready = 1'b0;
        pr_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        pr_ready = 1'b1;
        pr_rdata = 32'h1234_5678;
        model_reset();
        #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
        n_chk++; if (pr_req !== 1'b0) $display("FAIL reset_prreq: got %b want 0", pr_req); else n_pass++;
        n_chk++; if ({m0_ready, m1_ready, bus_err} !== 3'b000) $display("FAIL reset_ready_err: got %b want 000", {m0_ready, m1_ready, bus_err}); else n_pass++;
        n_chk++; if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); else n_pass++;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                m0_req = 1'b1; m0_rw = 1'b1; m0_a = 30'h2FF0_0000; m0_be = 4'hF;
                pr_ready = 1'b1; pr_rdata = 32'h3C08_1234;
            end
            if (i == 2) m0_req = 1'b0;
            #1 model_eval();
            n_chk++; if (act_v !== exp_v) $display("FAIL single_read c%0d: got %h want %h", i, act_v, exp_v); else n_pass++;
            if (i == 0) begin
                n_chk++; if ({grant, pr_req} !== 3'b000) $display("FAIL single_c0: got %b want 000", {grant, pr_req}); else n_pass++;
            end
            if (i == 1) begin
                n_chk++;
                if ({grant, pr_req, m0_ready, pr_a, m0_rdata} !== {2'b01, 1'b1, 1'b1, 30'h2FF0_0000, 32'h3C08_1234})
                    $display("FAIL single_c1: got %b %b %b %h %h want 01 1 1 2ff00000 3c081234", grant, pr_req, m0_ready, pr_a, m0_rdata);
                else n_pass++;
            end
            model_advance();
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            m0_req = 1'b1; m0_rw = 1'b1; m0_a = 30'h2400_0000; m0_be = 4'hF; m0_wdata = 32'h0;
            m1_req = 1'b1; m1_rw = 1'b0; m1_a = 30'h2800_01C0; m1_be = 4'hF; m1_wdata = 32'hDEAD_BEEF;
            pr_ready = 1'b1; pr_rdata = 32'h5500_0000 + 32'(i);
            #1 model_eval();
            n_chk++; if (act_v !== exp_v) $display("FAIL alternate c%0d: got %h want %h", i, act_v, exp_v); else n_pass++;
            if (i > 0) begin
                n_chk++;
                if ({grant, m0_ready, m1_ready} !== ((i % 2 == 1) ? 4'b0110 : 4'b1001))
                    $display("FAIL alternate_seq c%0d: got %b want %b", i, {grant, m0_ready, m1_ready}, (i % 2 == 1) ? 4'b0110 : 4'b1001);
                else n_pass++;
                n_chk++;
                if ((pr_wdata == 32'hDEAD_BEEF) !== (i % 2 == 0))
                    $display("FAIL alternate_wdata c%0d: got %h", i, pr_wdata);
                else n_pass++;
            end
            model_advance();
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                m1_req = 1'b1; m1_rw = 1'b1; m1_a = 30'h0000_1234; m1_be = 4'h3;
                m0_a = 30'h0000_0777; m0_rw = 1'b0; m0_wdata = 32'hCAFE_0001; m0_be = 4'hF;
            end
            if (i == 1) m0_req = 1'b1;
            if (i == 5) m1_req = 1'b0;
            if (i == 6) m0_req = 1'b0;
            pr_ready = (i >= 4);
            pr_rdata = 32'h0BAD_0000 + 32'(i);
            #1 model_eval();
            n_chk++; if (act_v !== exp_v) $display("FAIL wait_states c%0d: got %h want %h", i, act_v, exp_v); else n_pass++;
            if (i >= 1 && i <= 3) begin
                n_chk++;
                if ({m0_ready, m1_ready, pr_a} !== {2'b00, 30'h0000_1234})
                    $display("FAIL wait_hold c%0d: got %b %b %h want 0 0 00001234", i, m0_ready, m1_ready, pr_a);
                else n_pass++;
            end
            if (i == 4) begin
                n_chk++; if ({m1_ready, m1_rdata} !== {1'b1, 32'h0BAD_0004}) $display("FAIL wait_done: got %b %h want 1 0bad0004", m1_ready, m1_rdata); else n_pass++;
            end
            if (i == 5) begin
                n_chk++; if (grant !== 2'b01) $display("FAIL wait_handover: got %b want 01", grant); else n_pass++;
            end
            model_advance();
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_req = (i < 2); m0_rw = 1'b0; m0_a = 30'h0000_0042; m0_wdata = 32'h1111_2222; m0_be = 4'hF;
            pr_ready = 1'b0;
            #1 model_eval();
            n_chk++; if (act_v !== exp_v) $display("FAIL drop_req c%0d: got %h want %h", i, act_v, exp_v); else n_pass++;
            if (i == 2) begin
                n_chk++; if ({grant, pr_req, m0_ready} !== 4'b0100) $display("FAIL drop_same_cycle: got %b want 0100", {grant, pr_req, m0_ready}); else n_pass++;
            end
            if (i == 3) begin
                n_chk++; if ({grant, m0_ready} !== 3'b000) $display("FAIL drop_idle: got %b want 000", {grant, m0_ready}); else n_pass++;
            end
            model_advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        m1_req = 1'b1; m1_rw = 1'b1; m1_a = 30'h0000_0300; m1_be = 4'hF; pr_ready = 1'b0;
        #1 model_eval();
        model_advance();
        @(negedge clk);
        #1 model_eval();
        n_chk++; if ({grant, pr_req} !== 3'b101) $display("FAIL areset_pre: got %b want 101", {grant, pr_req}); else n_pass++;
        #1 rst_n = 1'b0;
        pr_ready = 1'b1;
        #1;
        n_chk++; if ({grant, pr_req, m0_ready, m1_ready} !== 5'b0) $display("FAIL areset_now: got %b want 00000", {grant, pr_req, m0_ready, m1_ready}); else n_pass++;
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        int readies = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) begin
                m0_req = 1'b1; m0_rw = 1'b1; m0_a = 30'h0000_0900; m0_be = 4'hF;
            end else if (e_r0) begin
                m0_req = 1'b0;
            end
            pr_ready = 1'b0; pr_rdata = 32'h7777_0000;
            #1 model_eval();
            n_chk++; if (act_v !== exp_v) $display("FAIL timeout c%0d: got %h want %h", i, act_v, exp_v); else n_pass++;
            if (m0_ready === 1'b1) readies++;
            if (i == 5) begin
                n_chk++;
                if ({m0_ready, pr_req, m0_rdata} !== {TO_EN, 1'b0 ^ !TO_EN, TO_EN ? 32'hFFFF_FFFF : 32'h0})
                    $display("FAIL timeout_hit: got %b %b %h want %b %b", m0_ready, pr_req, m0_rdata, TO_EN, !TO_EN);
                else n_pass++;
            end
            model_advance();
        end
        n_chk++; if (readies !== int'(TO_EN)) $display("FAIL timeout_pulses: got %0d want %0d", readies, TO_EN); else n_pass++;
        n_chk++; if (bus_err !== TO_EN) $display("FAIL timeout_sticky: got %b want %b", bus_err, TO_EN); else n_pass++;
    endtask

    task automatic test_random();
        int grants0 = 0, grants1 = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!m0_req || e_r0 || $urandom_range(31) == 0) begin
                m0_req = 1'($urandom_range(1)); m0_rw = 1'($urandom_range(1));
                m0_a = 30'($urandom); m0_be = 4'($urandom); m0_wdata = $urandom;
            end
            if (!m1_req || e_r1 || $urandom_range(31) == 0) begin
                m1_req = 1'($urandom_range(1)); m1_rw = 1'($urandom_range(1));
                m1_a = 30'($urandom); m1_be = 4'($urandom); m1_wdata = $urandom;
            end
            pr_ready = ($urandom_range(3) != 0);
            pr_rdata = $urandom;
            #1 model_eval();
            n_chk++; if (act_v !== exp_v) $display("FAIL random c%0d: got %h want %h", i, act_v, exp_v); else n_pass++;
            if (e_r0) grants0++;
            if (e_r1) grants1++;
            model_advance();
        end
        n_chk++; if (grants0 == 0 || grants1 == 0) $display("FAIL random_coverage: got m0=%0d m1=%0d completions", grants0, grants1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_wait_states();
        test_drop_req();
        test_async_reset();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
